ref_clock_out: RTL



---
 rtl/ref_clock_out.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/ref_clock_out.sv
// Integer clock divider producing the board reference output from the 250 MHz clock.
// Start/stop only happens on period boundaries, and divisor changes are applied at the next boundary.
module ref_clock_out #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] div,
  input  logic             div_valid,
  output logic             div_ready,
  input  logic             sync,
  output logic             ref_out,
  output logic             running,
  output logic             period_start,
  output logic [WIDTH-1:0] div_active,
  output logic             div_error
);

  localparam int W1 = WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             ref_q, ref_d;
  logic             ps_q, ps_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  logic             ready_q, ready_d;

  logic             wrap_s;
  logic             accept_s;
  logic             boundary_s;
  logic             to_idle_s;
  logic [W1-1:0]    half_s;

  assign wrap_s   = (cnt_q == (active_q - WIDTH'(1)));
  assign accept_s = div_valid & ready_q;
  // Odd divisors round the high phase up, so the extra cycle lands high.
  assign half_s   = ({1'b0, active_q} + W1'(1)) >> 1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ref_d      = ref_q;
    ps_d       = 1'b0;
    err_d      = 1'b0;
    active_d   = active_q;
    pend_d     = pend_q;
    pend_div_d = pend_div_q;
    boundary_s = 1'b0;
    to_idle_s  = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d    = RUN;
          boundary_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN, STOP: begin
        // A disabled output only leaves at the wrap, so the last period is always whole.
        if (wrap_s && !enable) begin
          to_idle_s = 1'b1;
        end else if (wrap_s || (sync && (state_q == RUN))) begin
          boundary_s = 1'b1;
        end else begin
          boundary_s = 1'b0;
        end
        state_d = enable ? RUN : STOP;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (boundary_s) begin
      cnt_d = '0;
      ref_d = 1'b1;
      ps_d  = 1'b1;
    end else if (to_idle_s) begin
      cnt_d   = '0;
      ref_d   = 1'b0;
      state_d = IDLE;
    end else if (state_q != IDLE) begin
      cnt_d = cnt_q + WIDTH'(1);
      ref_d = (({1'b0, cnt_q} + W1'(1)) < half_s);
    end else begin
      cnt_d = '0;
      ref_d = 1'b0;
    end

    if (pend_q && (boundary_s || to_idle_s || (state_q == IDLE))) begin
      active_d = pend_div_q;
      pend_d   = 1'b0;
    end else begin
      active_d = active_q;
    end

    // A transfer on a start edge waits for the next boundary like any other.
    if (accept_s) begin
      if (div < WIDTH'(2)) begin
        err_d = 1'b1;
      end else if ((state_q == IDLE) && !enable) begin
        active_d = div;
      end else begin
        pend_d     = 1'b1;
        pend_div_d = div;
      end
    end else begin
      err_d = 1'b0;
    end

    ready_d = ~pend_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ref_q      <= 1'b0;
      ps_q       <= 1'b0;
      err_q      <= 1'b0;
      active_q   <= WIDTH'(DEFAULT_DIV);
      pend_q     <= 1'b0;
      pend_div_q <= '0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ref_q      <= ref_d;
      ps_q       <= ps_d;
      err_q      <= err_d;
      active_q   <= active_d;
      pend_q     <= pend_d;
      pend_div_q <= pend_div_d;
      ready_q    <= ready_d;
    end
  end

  assign ref_out      = ref_q;
  assign running      = (state_q != IDLE);
  assign period_start = ps_q;
  assign div_active   = active_q;
  assign div_error    = err_q;
  assign div_ready    = ready_q;

endmodule
